// File: rtl/config_readback_tx_pkg.sv
// Shared constants, FSM state encoding and header byte mux for the config readback transmitter.
// The checksum trailer byte is enabled by defining CONFIG_READBACK_CHECKSUM_EN.
package config_readback_tx_pkg;

  localparam logic [2:0] HANDSHAKE = 3'b110;
  localparam int NUM_CH   = 8;
  localparam int CH_W     = 3;
  localparam int ADDR_W   = 5;
  localparam int MAX_ADDR = 31;
  localparam int HDR_LEN  = 6;
  localparam logic [2:0] HDR_LAST = 3'(HDR_LEN - 1);

  localparam int DELAY_LEN       = NUM_CH * (MAX_ADDR + 1);
  localparam int FRAME_LEN_BASE  = HDR_LEN + DELAY_LEN;
  localparam int FRAME_LEN_CKSUM = FRAME_LEN_BASE + 1;
`ifdef CONFIG_READBACK_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CKSUM;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif

  typedef enum logic [2:0] {
    READBACK_IDLE     = 3'd0,
    READBACK_HDR      = 3'd1,
    READBACK_RD_ISSUE = 3'd2,
    READBACK_RD_LATCH = 3'd3,
    READBACK_SEND     = 3'd4,
    READBACK_FINISH   = 3'd5
`ifdef CONFIG_READBACK_CHECKSUM_EN
    , READBACK_CKSUM  = 3'd6
`endif
  } readback_state_t;

  // Header byte idx of the frame, in the same order the loader parses it.
  function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                          input logic [7:0]  chan_sel,
                                          input logic [4:0]  aline_sel,
                                          input logic [31:0] pulse);
    case (idx)
      3'd0:    return {HANDSHAKE, chan_sel[7:3]};
      3'd1:    return {chan_sel[2:0], aline_sel};
      3'd2:    return pulse[31:24];
      3'd3:    return pulse[23:16];
      3'd4:    return pulse[15:8];
      default: return pulse[7:0];
    endcase
  endfunction

endpackage

// File: rtl/config_readback_tx_addr_gen.sv
// Channel/address scan counter for the delay stores; saturates at the last channel/address.
module readback_addr_gen
  import config_readback_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_advance,
  output logic [CH_W-1:0]   o_ch,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last_addr,
  output logic              o_last_ch
);

  logic [CH_W-1:0]   r_ch;
  logic [ADDR_W-1:0] r_addr;

  assign o_ch        = r_ch;
  assign o_addr      = r_addr;
  assign o_last_addr = (r_addr == ADDR_W'(MAX_ADDR));
  assign o_last_ch   = (r_ch == CH_W'(NUM_CH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_ch   <= '0;
      r_addr <= '0;
    end else if (i_advance) begin
      if (!o_last_addr) begin
        r_addr <= r_addr + ADDR_W'(1);
      end else if (!o_last_ch) begin
        r_addr <= '0;
        r_ch   <= r_ch + CH_W'(1);
      end
    end
  end

endmodule

// File: rtl/config_readback_tx.sv
// Serializes a snapshot of the image configuration plus all delay stores as a UART byte frame.
// Optional trailing XOR checksum byte when CONFIG_READBACK_CHECKSUM_EN is defined.
module config_readback_tx
  import config_readback_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [7:0]        i_channel_select,
  input  logic [4:0]        i_aline_select,
  input  logic [31:0]       i_pulse_shape,
  output logic [CH_W-1:0]   o_rd_ch,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [7:0]        i_rd_data,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_done
);

  readback_state_t r_state, w_next_state;

  logic [2:0]  r_hdr_idx;
  logic [7:0]  r_snap_cs;
  logic [4:0]  r_snap_al;
  logic [31:0] r_snap_ps;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
`ifdef CONFIG_READBACK_CHECKSUM_EN
  logic [7:0]  r_cksum;
`endif

  logic w_xfer, w_accept, w_addr_clear, w_addr_adv;
  logic w_last_addr, w_last_ch, w_last_byte, w_hdr_done;

  assign w_xfer      = r_tx_valid & i_tx_ready;
  assign w_last_byte = w_last_addr & w_last_ch;
  assign w_hdr_done  = w_xfer && (r_hdr_idx == HDR_LAST);
  assign o_tx_data   = r_tx_data;
  assign o_tx_valid  = r_tx_valid;

  readback_addr_gen u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_addr_clear),
    .i_advance   (w_addr_adv),
    .o_ch        (o_rd_ch),
    .o_addr      (o_rd_addr),
    .o_last_addr (w_last_addr),
    .o_last_ch   (w_last_ch)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= READBACK_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_addr_clear = 1'b0;
    w_addr_adv   = 1'b0;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    case (r_state)
      READBACK_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_accept     = 1'b1;
          w_next_state = READBACK_HDR;
        end
      end
      READBACK_HDR: begin
        if (w_hdr_done) begin
          w_addr_clear = 1'b1;
          w_next_state = READBACK_RD_ISSUE;
        end
      end
      READBACK_RD_ISSUE: w_next_state = READBACK_RD_LATCH;
      READBACK_RD_LATCH: w_next_state = READBACK_SEND;
      READBACK_SEND: begin
        if (w_xfer) begin
          if (w_last_byte) begin
`ifdef CONFIG_READBACK_CHECKSUM_EN
            w_next_state = READBACK_CKSUM;
`else
            w_next_state = READBACK_FINISH;
`endif
          end else begin
            w_addr_adv   = 1'b1;
            w_next_state = READBACK_RD_ISSUE;
          end
        end
      end
`ifdef CONFIG_READBACK_CHECKSUM_EN
      READBACK_CKSUM: begin
        if (w_xfer) w_next_state = READBACK_FINISH;
      end
`endif
      READBACK_FINISH: begin
        o_busy       = 1'b0;
        o_done       = 1'b1;
        w_next_state = READBACK_IDLE;
      end
      default: begin
        o_busy       = 1'b0;
        w_next_state = READBACK_IDLE;
      end
    endcase
  end

  // Byte 0 comes straight from the inputs; the rest of the header uses the snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hdr_idx  <= '0;
      r_snap_cs  <= '0;
      r_snap_al  <= '0;
      r_snap_ps  <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
`ifdef CONFIG_READBACK_CHECKSUM_EN
      r_cksum    <= '0;
`endif
    end else begin
`ifdef CONFIG_READBACK_CHECKSUM_EN
      if (w_accept)    r_cksum <= '0;
      else if (w_xfer) r_cksum <= r_cksum ^ r_tx_data;
`endif
      case (r_state)
        READBACK_IDLE: begin
          if (w_accept) begin
            r_snap_cs  <= i_channel_select;
            r_snap_al  <= i_aline_select;
            r_snap_ps  <= i_pulse_shape;
            r_hdr_idx  <= 3'd0;
            r_tx_data  <= hdr_byte(3'd0, i_channel_select, i_aline_select, i_pulse_shape);
            r_tx_valid <= 1'b1;
          end
        end
        READBACK_HDR: begin
          if (w_hdr_done) begin
            r_tx_valid <= 1'b0;
          end else if (w_xfer) begin
            r_hdr_idx <= r_hdr_idx + 3'd1;
            r_tx_data <= hdr_byte(r_hdr_idx + 3'd1, r_snap_cs, r_snap_al, r_snap_ps);
          end
        end
        READBACK_RD_LATCH: begin
          r_tx_data  <= i_rd_data;
          r_tx_valid <= 1'b1;
        end
        READBACK_SEND: begin
          if (w_xfer) begin
`ifdef CONFIG_READBACK_CHECKSUM_EN
            if (w_last_byte) r_tx_data  <= r_cksum ^ r_tx_data;
            else             r_tx_valid <= 1'b0;
`else
            r_tx_valid <= 1'b0;
`endif
          end
        end
`ifdef CONFIG_READBACK_CHECKSUM_EN
        READBACK_CKSUM: begin
          if (w_xfer) r_tx_valid <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_config_readback_tx.sv
// Directed self-checking bench for config_readback_tx; delay stores hold data = {ch, addr}.
`timescale 1ns/1ps
module tb_config_readback_tx;

`ifdef CONFIG_READBACK_CHECKSUM_EN
  localparam int FRAME_N = 263;
`else
  localparam int FRAME_N = 262;
`endif
  localparam int CYC_MAX = 5000;

  // {110,10100}, {101,10011}, then pulse_shape 0000001F MSB first.
  localparam logic [7:0] HDR_EXP [6] = '{8'hD4, 8'hB3, 8'h00, 8'h00, 8'h00, 8'h1F};

  logic        clk = 1'b0;
  logic        rst, start, tx_ready;
  logic [7:0]  cs;
  logic [4:0]  al;
  logic [31:0] ps;
  logic [2:0]  rd_ch;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_data = 8'h00;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  int done_cnt = 0;
  int busy_err = 0;
  int stall_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic [7:0] cap[$];
  int         cap_t[$];

  always #5 clk = ~clk;

  config_readback_tx dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (start),
    .i_channel_select (cs),
    .i_aline_select   (al),
    .i_pulse_shape    (ps),
    .o_rd_ch          (rd_ch),
    .o_rd_addr        (rd_addr),
    .i_rd_data        (rd_data),
    .o_tx_data        (tx_data),
    .o_tx_valid       (tx_valid),
    .i_tx_ready       (tx_ready),
    .o_busy           (busy),
    .o_done           (done)
  );

  // Registered store read: data valid one cycle after the address changes.
  always @(posedge clk) begin
    rd_data <= {rd_ch, rd_addr};
    cyc_cnt <= cyc_cnt + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(tx_valid && tx_data == prev_data)) stall_err++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) begin
        cap.push_back(tx_data);
        cap_t.push_back(cyc_cnt);
        if (!busy) busy_err++;
      end
      if (done) begin
        done_cnt++;
        if (busy) busy_err++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    tx_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode 0: ready high; 1: random ready with a 50-cycle stall at byte 7;
  // 2: change inputs + start at byte 3 and start during FINISH; 3: reset at ch3 addr 10.
  task automatic run_frame(input int mode, output bit finished);
    int  d0 = done_cnt;
    int  hold = 0;
    bit  held = 0, snapped = 0, fin_start = 0, rst_done = 0;
    cap.delete();
    cap_t.delete();
    finished = 0;
    start    = 1'b1;
    tx_ready = 1'b1;
    for (int c = 0; c < CYC_MAX; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (rst_done) begin
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_ch", 32'(rd_ch), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        rst = 1'b0;
        finished = 1;
        return;
      end
      if (done_cnt != d0) begin
        finished = 1;
        return;
      end
      case (mode)
        1: begin
          if (!held && cap.size() == 7) begin
            held = 1;
            hold = 50;
          end
          if (hold > 0) begin
            tx_ready = 1'b0;
            hold--;
            if (hold == 0) begin
              check("bp_hold_valid", 32'(tx_valid), 32'd1);
              check("bp_hold_data", 32'(tx_data), 32'h01);
            end
          end else begin
            tx_ready = 1'($urandom_range(0, 1));
          end
        end
        2: begin
          tx_ready = 1'b1;
          if (!snapped && cap.size() == 3) begin
            snapped = 1;
            cs      = 8'h00;
            ps      = 32'hFFFF_FFFF;
            start   = 1'b1;
          end
          if (!fin_start && cap.size() == FRAME_N) begin
            fin_start = 1;
            start     = 1'b1;
          end
        end
        3: begin
          tx_ready = 1'b1;
          if (rd_ch == 3'd3 && rd_addr == 5'd10) begin
            rst      = 1'b1;
            rst_done = 1;
          end
        end
        default: tx_ready = 1'b1;
      endcase
    end
    $display("FAIL %s_timeout: got %0d cycles expected done", "frame", CYC_MAX);
  endtask

  task automatic check_frame(input string tag);
    int errs = 0;
    logic [8:0] ck;
    check({tag, "_len"}, 32'(cap.size()), 32'(FRAME_N));
    for (int i = 0; i < 6; i++)
      check($sformatf("%s_hdr%0d", tag, i), 32'(cap[i]), 32'(HDR_EXP[i]));
    for (int i = 6; i < 262; i++)
      if (i >= cap.size() || cap[i] !== 8'(i - 6)) errs++;
    check({tag, "_delay_errs"}, 32'(errs), 32'd0);
`ifdef CONFIG_READBACK_CHECKSUM_EN
    // XOR of 0..255 is 0, so the checksum is the header XOR: D4^B3^1F.
    ck = (cap.size() > 262) ? {1'b0, cap[262]} : 9'h100;
    check({tag, "_cksum"}, 32'(ck), 32'h78);
`else
    ck = 9'h000;
`endif
  endtask

  initial begin
    bit fin;
    int d0;
    rst = 1'b1; start = 1'b0; tx_ready = 1'b0;
    cs = 8'hA5; al = 5'h13; ps = 32'h0000_001F;
    repeat (3) @(posedge clk); #1;
    check("reset_tx_valid", 32'(tx_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_rd_ch", 32'(rd_ch), 32'd0);
    check("reset_rd_addr", 32'(rd_addr), 32'd0);
    rst = 1'b0;
    idle(2);

    // Full frame with tx_ready always high.
    d0 = done_cnt;
    run_frame(0, fin);
    check("full_finished", 32'(fin), 32'd1);
    check("full_busy_low", 32'(busy), 32'd0);
    idle(10);
    check_frame("full");
    check("full_done_once", 32'(done_cnt - d0), 32'd1);
    check("full_hdr_b2b", 32'(cap_t[1] - cap_t[0]), 32'd1);
    check("full_first_delay_gap", 32'(cap_t[6] - cap_t[5]), 32'd3);
    check("full_delay_gap", 32'(cap_t[100] - cap_t[99]), 32'd3);
    check("full_ch_boundary", 32'(cap[38]), 32'h20);
    check("full_last_rd_ch", 32'(rd_ch), 32'd7);
    check("full_last_rd_addr", 32'(rd_addr), 32'd31);

    // Random backpressure with a long stall.
    d0 = done_cnt;
    run_frame(1, fin);
    check("bp_finished", 32'(fin), 32'd1);
    idle(10);
    check_frame("bp");
    check("bp_done_once", 32'(done_cnt - d0), 32'd1);

    // Snapshot and ignored starts (mid-frame and during FINISH).
    d0 = done_cnt;
    run_frame(2, fin);
    check("snap_finished", 32'(fin), 32'd1);
    idle(20);
    check("snap_no_second_busy", 32'(busy), 32'd0);
    check("snap_no_second_valid", 32'(tx_valid), 32'd0);
    check_frame("snap");
    check("snap_done_once", 32'(done_cnt - d0), 32'd1);
    cs = 8'hA5; ps = 32'h0000_001F;

    // Reset mid-frame, then a clean frame.
    d0 = done_cnt;
    run_frame(3, fin);
    check("rstmid_reached", 32'(fin), 32'd1);
    idle(10);
    check("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
    run_frame(0, fin);
    check("after_rst_finished", 32'(fin), 32'd1);
    idle(10);
    check_frame("after_rst");
    check("after_rst_done_once", 32'(done_cnt - d0), 32'd1);

    check("stall_stable_errs", 32'(stall_err), 32'd0);
    check("busy_errs", 32'(busy_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
